data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 128, data-memory words (address width 7).
REQ-002 SHALL provide parameter DW, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 core_cen  input  1  chip enable from processor, active-low.
REQ-006 core_wen  input  1  write enable from processor; 0 = write, 1 = read.
REQ-007 core_oen  input  1  output enable from processor, active-low.
REQ-008 core_a  input  7  processor word address.
REQ-009 core_d  input  32  processor write data.
REQ-010 core_q  output  32  processor read data.
REQ-011 cmd_valid, cmd_ready  input/output  1 each  host command handshake.
REQ-012 cmd_op  input  1  0 = LOAD (host writes memory), 1 = DUMP (host reads memory).
REQ-013 cmd_base  input  7  start word address; cmd_len  input  7  word count, 0 encodes 128.
REQ-014 ld_valid, ld_ready  input/output  1 each; ld_data  input  32  load stream.
REQ-015 dp_valid, dp_ready  output/input  1 each; dp_data  output  32  dump stream.
REQ-016 busy  output  1  high outside IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-017 core_q SHALL equal mem[core_a] combinationally when core_cen=0, core_oen=0, core_wen=1; otherwise 32'h0.
REQ-018 Processor write SHALL update mem[core_a] with core_d at the rising edge when core_cen=0 and core_wen=0, in every state.
REQ-019 FSM states SHALL be IDLE, LOAD, DUMP, DONE.
REQ-020 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready, the block SHALL latch base/len and enter LOAD or DUMP next cycle, address pointer = cmd_base, count = 0.
REQ-021 In LOAD, ld_ready SHALL be 0 in any cycle with a processor write (processor priority), else 1.
REQ-022 In LOAD, each ld_valid&ld_ready beat SHALL write ld_data to mem[ptr] at the edge, then ptr = (ptr+1) mod 128, count+1.
REQ-023 In DUMP, dp_valid SHALL be 1 and dp_data SHALL equal current mem[ptr] (pre-edge contents); each dp_valid&dp_ready beat SHALL advance ptr mod 128 and count.
REQ-024 After the beat making count equal to len, the FSM SHALL enter DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 ld_ready SHALL be 0 outside LOAD; dp_valid SHALL be 0 outside DUMP; dp_data SHALL be 0 outside DUMP.
REQ-026 Pointer wrap from 127 to 0 SHALL occur without stall or error.
REQ-027 Processor write and dump read to the same address in one cycle: dp_data SHALL show the old value; the new value is visible next cycle.
REQ-028 Stalled stream (ld_valid=0 or dp_ready=0) SHALL hold ptr, count, state indefinitely.

Reset
REQ-029 While rst=1 at an edge: state = IDLE, ptr = 0, count = 0, latched len = 0, all memory words = 0.
REQ-030 Outputs after reset: cmd_ready=1, busy=0, done=0, ld_ready=0, dp_valid=0, dp_data=0; core_q per REQ-017 (0 on any read).
REQ-031 Reset mid-LOAD/DUMP SHALL abort without a done pulse; no partial-command state survives.

Structure
REQ-032 Shared package dmem_pkg SHALL hold DEPTH, AW=7, DW=32, FSM state encoding, and cmd_op codes.
REQ-033 Storage SHALL be one sub-module dmem_array: one combinational read port per consumer, two prioritized write ports (processor over host), synchronous clear.

Verification
REQ-034 Reset, then processor write 0xDEADBEEF to A=5, read A=5 with oen=0 -> core_q=0xDEADBEEF; with oen=1 -> 0.
REQ-035 LOAD base=126 len=4, data 1,2,3,4 -> mem[126]=1, mem[127]=2, mem[0]=3, mem[1]=4; done pulses once; busy falls same cycle FSM leaves DONE.
REQ-036 DUMP base=0 len=0 with dp_ready toggling every cycle -> 128 beats in address order, values unchanged, no beat lost or duplicated.
REQ-037 LOAD in progress, processor writes A=10 while ld_valid=1 -> ld_ready=0 that cycle, processor data stored, host beat applied next cycle at unchanged ptr.
REQ-038 DUMP ptr=3, same-cycle processor write 0x55 to A=3, dp_ready=0 -> dp_data old value that cycle, 0x55 next cycle.
REQ-039 rst asserted mid-DUMP after 2 of 8 beats -> next cycle IDLE, cmd_ready=1, no done, mem[3] reads 0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared constants, FSM state encoding and host command opcodes for the data-memory responder.
package dmem_pkg;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_DUMP = 1'b1
  } cmd_op_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// Processor port, host command channel and load/dump streams of the responder.
interface dmem_if #(
  parameter int AW = dmem_pkg::AW,
  parameter int DW = dmem_pkg::DW
);
  logic          core_cen;
  logic          core_wen;
  logic          core_oen;
  logic [AW-1:0] core_a;
  logic [DW-1:0] core_d;
  logic [DW-1:0] core_q;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW-1:0] cmd_len;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          dp_valid;
  logic          dp_ready;
  logic [DW-1:0] dp_data;
  logic          busy;
  logic          done;

  modport master (
    output core_cen, core_wen, core_oen, core_a, core_d,
    input  core_q,
    output cmd_valid, cmd_op, cmd_base, cmd_len,
    input  cmd_ready,
    output ld_valid, ld_data,
    input  ld_ready,
    input  dp_valid, dp_data,
    output dp_ready,
    input  busy, done
  );

  modport slave (
    input  core_cen, core_wen, core_oen, core_a, core_d,
    output core_q,
    input  cmd_valid, cmd_op, cmd_base, cmd_len,
    output cmd_ready,
    input  ld_valid, ld_data,
    output ld_ready,
    output dp_valid, dp_data,
    input  dp_ready,
    output busy, done
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// Word storage with two combinational read ports and two write ports; the processor port
// wins an address collision. Whole array clears synchronously on rst.
module dmem_array #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pwr_en,
  input  logic [AW-1:0] i_pwr_addr,
  input  logic [DW-1:0] i_pwr_data,
  input  logic          i_hwr_en,
  input  logic [AW-1:0] i_hwr_addr,
  input  logic [DW-1:0] i_hwr_data,
  input  logic [AW-1:0] i_rd_core_addr,
  output logic [DW-1:0] o_rd_core_data,
  input  logic [AW-1:0] i_rd_dump_addr,
  output logic [DW-1:0] o_rd_dump_data
);
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_hwr_ok;

  assign w_hwr_ok = i_hwr_en && !(i_pwr_en && (i_pwr_addr == i_hwr_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_hwr_ok) r_mem[i_hwr_addr] <= i_hwr_data;
      if (i_pwr_en) r_mem[i_pwr_addr] <= i_pwr_data;
    end
  end

  assign o_rd_core_data = r_mem[i_rd_core_addr];
  assign o_rd_dump_data = r_mem[i_rd_dump_addr];
endmodule

// File: rtl/data_mem_responder.sv
// Processor-facing data memory with a host LOAD/DUMP engine; core reads are combinational,
// host beats complete in the accepting cycle, and processor writes stall the load stream one cycle.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = dmem_pkg::DEPTH,
  parameter int DW    = dmem_pkg::DW
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_len, w_len_nxt;
  logic          w_proc_wr, w_proc_rd;
  logic          w_ld_rdy, w_dp_vld, w_beat;
  logic [DW-1:0] w_rd_core, w_rd_dump;

  assign w_proc_wr = !bus.core_cen && !bus.core_wen;
  assign w_proc_rd = !bus.core_cen && !bus.core_oen && bus.core_wen;

  dmem_array #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_array (
    .clk            (clk),
    .rst            (rst),
    .i_pwr_en       (w_proc_wr),
    .i_pwr_addr     (bus.core_a),
    .i_pwr_data     (bus.core_d),
    .i_hwr_en       (w_beat && (r_state == ST_LOAD)),
    .i_hwr_addr     (r_ptr),
    .i_hwr_data     (bus.ld_data),
    .i_rd_core_addr (bus.core_a),
    .o_rd_core_data (w_rd_core),
    .i_rd_dump_addr (r_ptr),
    .o_rd_dump_data (w_rd_dump)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_ld_rdy    = 1'b0;
    w_dp_vld    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt = (cmd_op_t'(bus.cmd_op) == OP_DUMP) ? ST_DUMP : ST_LOAD;
          w_ptr_nxt   = bus.cmd_base;
          w_cnt_nxt   = '0;
          // A zero length field means a full sweep of the memory.
          w_len_nxt   = (bus.cmd_len == '0) ? CW'(DEPTH) : {1'b0, bus.cmd_len};
        end
      end
      ST_LOAD: begin
        w_ld_rdy = !w_proc_wr;
        w_beat   = bus.ld_valid && w_ld_rdy;
      end
      ST_DUMP: begin
        w_dp_vld = 1'b1;
        w_beat   = bus.dp_ready;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_beat) begin
      w_ptr_nxt = r_ptr + AW'(1);
      w_cnt_nxt = r_cnt + CW'(1);
      if ((r_cnt + CW'(1)) == r_len) w_state_nxt = ST_DONE;
    end
  end

  assign bus.core_q    = w_proc_rd ? w_rd_core : '0;
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.ld_ready  = w_ld_rdy;
  assign bus.dp_valid  = w_dp_vld;
  assign bus.dp_data   = w_dp_vld ? w_rd_dump : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: processor-port vector table plus hand-written LOAD/DUMP/reset sequences.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_mem [128];

  dmem_if bus ();

  data_mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cen;
    logic        wen;
    logic        oen;
    logic [6:0]  a;
    logic [31:0] d;
    logic [31:0] q;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    bus.core_cen = 1'b1;
    bus.core_wen = 1'b1;
    bus.core_oen = 1'b1;
    bus.core_a   = '0;
    bus.core_d   = '0;
  endtask

  task automatic core_read_chk(input logic [6:0] a, input logic [31:0] exp, input string name);
    bus.core_cen = 1'b0;
    bus.core_wen = 1'b1;
    bus.core_oen = 1'b0;
    bus.core_a   = a;
    #1;
    chk(name, bus.core_q, exp);
    core_idle();
  endtask

  task automatic issue(input logic op, input logic [6:0] base, input logic [6:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    #1;
    chk("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int cyc;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 7'd5,   32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 7'd5,   32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 7'd5,   32'h0,        32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 7'd5,   32'h0,        32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 7'd127, 32'h12345678, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 7'd127, 32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 7'd6,   32'h0,        32'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 7'd5,   32'hCAFEF00D, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 7'd5,   32'h0,        32'hCAFEF00D};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 7'd3,   32'h00000033, 32'h0};

    for (int i = 0; i < 128; i++) exp_mem[i] = '0;
    core_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.dp_ready  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst busy",      {31'b0, bus.busy},      32'd0);
    chk("rst done",      {31'b0, bus.done},      32'd0);
    chk("rst ld_ready",  {31'b0, bus.ld_ready},  32'd0);
    chk("rst dp_valid",  {31'b0, bus.dp_valid},  32'd0);
    chk("rst dp_data",   bus.dp_data,            32'd0);
    core_read_chk(7'd0, 32'h0, "rst core_q");

    // Processor port vectors
    for (int i = 0; i < 10; i++) begin
      bus.core_cen = vecs[i].cen;
      bus.core_wen = vecs[i].wen;
      bus.core_oen = vecs[i].oen;
      bus.core_a   = vecs[i].a;
      bus.core_d   = vecs[i].d;
      #1;
      chk($sformatf("vec%0d core_q", i), bus.core_q, vecs[i].q);
      if (!vecs[i].cen && !vecs[i].wen) exp_mem[vecs[i].a] = vecs[i].d;
      tick();
    end
    core_idle();

    // LOAD across the wrap point with one stalled cycle
    issue(1'b0, 7'd126, 7'd4);
    chk("load busy", {31'b0, bus.busy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        bus.ld_valid = 1'b0;
        #1;
        chk("load stall busy", {31'b0, bus.busy}, 32'd1);
        chk("load stall done", {31'b0, bus.done}, 32'd0);
        tick();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'(k + 1);
      #1;
      chk($sformatf("load beat%0d ld_ready", k), {31'b0, bus.ld_ready}, 32'd1);
      chk($sformatf("load beat%0d done", k), {31'b0, bus.done}, 32'd0);
      exp_mem[7'(126 + k)] = 32'(k + 1);
      tick();
    end
    bus.ld_valid = 1'b0;
    #1;
    chk("load done pulse", {31'b0, bus.done}, 32'd1);
    chk("load done busy",  {31'b0, bus.busy}, 32'd1);
    tick();
    chk("load after done",      {31'b0, bus.done},      32'd0);
    chk("load after busy",      {31'b0, bus.busy},      32'd0);
    chk("load after cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    core_read_chk(7'd126, 32'd1, "mem126");
    core_read_chk(7'd127, 32'd2, "mem127");
    core_read_chk(7'd0,   32'd3, "mem0");
    core_read_chk(7'd1,   32'd4, "mem1");

    // LOAD with a colliding processor write
    issue(1'b0, 7'd8, 7'd2);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hA0;
    #1;
    chk("coll beat0 ld_ready", {31'b0, bus.ld_ready}, 32'd1);
    exp_mem[8] = 32'hA0;
    tick();
    bus.ld_data  = 32'hA1;
    bus.core_cen = 1'b0;
    bus.core_wen = 1'b0;
    bus.core_a   = 7'd10;
    bus.core_d   = 32'h77;
    #1;
    chk("coll proc ld_ready", {31'b0, bus.ld_ready}, 32'd0);
    exp_mem[10] = 32'h77;
    tick();
    core_idle();
    #1;
    chk("coll retry ld_ready", {31'b0, bus.ld_ready}, 32'd1);
    exp_mem[9] = 32'hA1;
    tick();
    bus.ld_valid = 1'b0;
    #1;
    chk("coll done", {31'b0, bus.done}, 32'd1);
    tick();
    core_read_chk(7'd8,  32'hA0, "coll mem8");
    core_read_chk(7'd9,  32'hA1, "coll mem9");
    core_read_chk(7'd10, 32'h77, "coll mem10");

    // Full-memory DUMP with toggling dp_ready
    issue(1'b1, 7'd0, 7'd0);
    beats = 0;
    cyc   = 0;
    while (beats < 128 && cyc < 1000) begin
      bus.dp_ready = cyc[0];
      #1;
      chk($sformatf("dump%0d dp_valid", beats), {31'b0, bus.dp_valid}, 32'd1);
      chk($sformatf("dump%0d dp_data", beats), bus.dp_data, exp_mem[beats]);
      if (bus.dp_ready) beats++;
      tick();
      cyc++;
    end
    bus.dp_ready = 1'b0;
    chk("dump beat count", 32'(beats), 32'd128);
    #1;
    chk("dump done",       {31'b0, bus.done},     32'd1);
    chk("dump done dp_vld", {31'b0, bus.dp_valid}, 32'd0);
    chk("dump done dp_dat", bus.dp_data,           32'd0);
    tick();

    // DUMP with same-cycle processor write to the dump pointer
    issue(1'b1, 7'd3, 7'd4);
    bus.dp_ready = 1'b0;
    bus.core_cen = 1'b0;
    bus.core_wen = 1'b0;
    bus.core_a   = 7'd3;
    bus.core_d   = 32'h55;
    #1;
    chk("rw old dp_data", bus.dp_data, 32'h33);
    exp_mem[3] = 32'h55;
    tick();
    core_idle();
    #1;
    chk("rw new dp_data", bus.dp_data, 32'h55);
    bus.dp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rw beat%0d dp_data", k), bus.dp_data, exp_mem[3 + k]);
      tick();
    end
    bus.dp_ready = 1'b0;
    #1;
    chk("rw done", {31'b0, bus.done}, 32'd1);
    tick();

    // Reset in the middle of a DUMP
    issue(1'b1, 7'd0, 7'd8);
    bus.dp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("abort beat%0d dp_data", k), bus.dp_data, exp_mem[k]);
      tick();
    end
    bus.dp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 128; i++) exp_mem[i] = '0;
    #1;
    chk("abort cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("abort busy",      {31'b0, bus.busy},      32'd0);
    chk("abort done",      {31'b0, bus.done},      32'd0);
    chk("abort dp_valid",  {31'b0, bus.dp_valid},  32'd0);
    core_read_chk(7'd3, exp_mem[3], "abort mem3");
    tick();
    chk("abort done later", {31'b0, bus.done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
